// File: rtl/multdiv_ctrl.sv
// HI/LO sequencer: launches the pipelined multiplier or iterative divider from E and stalls E until HI/LO are ready.
// Optional define MULDIV_EARLY_OUT_EN: divides with |a| < |b| complete without starting the divider.
module multdiv_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned W       = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_i,
  input  logic [2:0]     op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           stall_ext_i,
  input  logic           flush_i,
  output logic           ok_o,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o,
  output logic           mul_start_o,
  output logic           mul_sign_o,
  output logic [W-1:0]   mul_a_o,
  output logic [W-1:0]   mul_b_o,
  input  logic [2*W-1:0] mul_p_i,
  output logic           div_start_o,
  output logic           div_sign_o,
  output logic           div_abort_o,
  output logic [W-1:0]   div_a_o,
  output logic [W-1:0]   div_b_o,
  input  logic           div_done_i,
  input  logic [W-1:0]   div_q_i,
  input  logic [W-1:0]   div_r_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  logic [1:0]   state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [W-1:0] hi_nxt, lo_nxt;
  logic         is_mul, is_div, is_signed, div_zero, early_out;

  assign is_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign div_zero  = (b_i == '0);

  assign mul_a_o    = a_i;
  assign mul_b_o    = b_i;
  assign div_a_o    = a_i;
  assign div_b_o    = b_i;
  assign mul_sign_o = is_signed;
  assign div_sign_o = is_signed;

`ifdef MULDIV_EARLY_OUT_EN
  logic [W-1:0] a_mag, b_mag;

  // Two's-complement negate of the most negative value yields its true magnitude as unsigned.
  always_comb begin
    a_mag = a_i;
    b_mag = b_i;
    if (op_i == OP_DIV) begin
      if (a_i[W-1]) a_mag = '0 - a_i;
      if (b_i[W-1]) b_mag = '0 - b_i;
    end
  end

  assign early_out = (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi_o;
    lo_nxt      = lo_o;
    ok_o        = 1'b1;
    mul_start_o = 1'b0;
    div_start_o = 1'b0;
    div_abort_o = 1'b0;

    case (state)
      S_IDLE: begin
        if (valid_i && (is_mul || is_div) && !flush_i && !reset) begin
          ok_o = 1'b0;
          if (is_mul) begin
            mul_start_o = 1'b1;
            cnt_nxt     = CNT_INIT;
            state_nxt   = S_MUL;
          end else if (div_zero) begin
            hi_nxt    = a_i;
            lo_nxt    = '1;
            state_nxt = S_DONE;
          end else if (early_out) begin
            hi_nxt    = a_i;
            lo_nxt    = '0;
            state_nxt = S_DONE;
          end else begin
            div_start_o = 1'b1;
            state_nxt   = S_DIV;
          end
        end
      end
      S_MUL: begin
        ok_o = 1'b0;
        if (cnt == '0) begin
          {hi_nxt, lo_nxt} = mul_p_i;
          state_nxt        = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DIV: begin
        ok_o = 1'b0;
        if (div_done_i) begin
          hi_nxt    = div_r_i;
          lo_nxt    = div_q_i;
          state_nxt = S_DONE;
        end
      end
      default: begin
        if (!stall_ext_i) state_nxt = S_IDLE;
      end
    endcase

    // Flush overrides whatever the state decided: drop the op and keep the previous HI/LO.
    if (flush_i) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      hi_nxt    = hi_o;
      lo_nxt    = lo_o;
      if (state == S_DIV && !reset) div_abort_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi_o  <= hi_nxt;
      lo_o  <= lo_nxt;
    end
  end

endmodule
